// File: rtl/hilo_pkg.sv
// Shared encodings, FSM states and helpers for the HI/LO multiply/divide controller.
package hilo_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam int DIV_ITER = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_WAIT = 3'd1,
    ST_DIV_RUN  = 3'd2,
    ST_DIV_FIX  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if it fits.
module div_step (
  input  logic [32:0] rem,
  input  logic        dvd_msb,
  input  logic [31:0] divisor,
  output logic [32:0] next_rem,
  output logic        qbit
);

  logic [33:0] shifted;
  logic [33:0] trial;

  assign shifted  = {rem, dvd_msb};
  assign trial    = shifted - {2'b00, divisor};
  assign qbit     = ~trial[33];
  assign next_rem = qbit ? trial[32:0] : shifted[32:0];

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO controller sitting behind the external combinational Booth multiplier:
// operand registering, product capture, iterative signed divide and MTHI/MTLO.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_IDLE     | waiting for start
//   ST_MUL_WAIT | multiplier operands held, counting down settle time
//   ST_DIV_RUN  | one restoring divide step per cycle, MSB first
//   ST_DIV_FIX  | apply quotient/remainder signs, write HI/LO
//   ST_DONE     | done pulse; a new start is accepted here as in IDLE
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [31:0]      dvd;
  logic [31:0]      dsr;
  logic [32:0]      rem;
  logic             rem_neg;
  logic             quo_neg;
  logic             dbz;

  logic             ld_mul, ld_div, ld_dbz, wr_hi, wr_lo;
  logic             cap_mul, run_div, fix_div, dec_cnt;
  logic             cnt_zero;

  logic [32:0]      step_rem;
  logic             step_qbit;

  assign cnt_zero = (cnt == '0);

  div_step u_div_step (
    .rem      (rem),
    .dvd_msb  (dvd[31]),
    .divisor  (dsr),
    .next_rem (step_rem),
    .qbit     (step_qbit)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    ld_mul     = 1'b0;
    ld_div     = 1'b0;
    ld_dbz     = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    cap_mul    = 1'b0;
    run_div    = 1'b0;
    fix_div    = 1'b0;
    dec_cnt    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        done       = (state == ST_DONE);
        state_next = ST_IDLE;
        if (start) begin
          case (op)
            OP_MUL: begin
              ld_mul     = 1'b1;
              state_next = ST_MUL_WAIT;
            end
            OP_DIV: begin
              if (b == 32'd0) begin
                ld_dbz     = 1'b1;
                state_next = ST_DONE;
              end else begin
                ld_div     = 1'b1;
                state_next = ST_DIV_RUN;
              end
            end
            OP_MTHI: begin
              wr_hi      = 1'b1;
              state_next = ST_DONE;
            end
            default: begin
              wr_lo      = 1'b1;
              state_next = ST_DONE;
            end
          endcase
        end
      end
      ST_MUL_WAIT: begin
        busy = 1'b1;
        if (cnt_zero) begin
          cap_mul    = 1'b1;
          state_next = ST_DONE;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      ST_DIV_RUN: begin
        busy    = 1'b1;
        run_div = 1'b1;
        if (cnt_zero) state_next = ST_DIV_FIX;
        else          dec_cnt    = 1'b1;
      end
      ST_DIV_FIX: begin
        busy       = 1'b1;
        fix_div    = 1'b1;
        state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign div_by_zero = done & dbz;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      mul_a   <= '0;
      mul_b   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      dvd     <= '0;
      dsr     <= '0;
      rem     <= '0;
      rem_neg <= 1'b0;
      quo_neg <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      dbz <= ld_dbz;

      if (ld_mul) begin
        mul_a <= a;
        mul_b <= b;
        cnt   <= CNT_W'(MUL_LAT - 1);
      end

      if (ld_div) begin
        dvd     <= abs32(a);
        dsr     <= abs32(b);
        rem     <= '0;
        rem_neg <= a[31];
        quo_neg <= a[31] ^ b[31];
        cnt     <= CNT_W'(DIV_ITER - 1);
      end

      if (dec_cnt) cnt <= cnt - 1'b1;

      // Quotient bits shift into the dividend register as its bits are consumed.
      if (run_div) begin
        rem <= step_rem;
        dvd <= {dvd[30:0], step_qbit};
      end

      if (cap_mul) begin
        hi <= mul_hi;
        lo <= mul_lo;
      end

      if (fix_div) begin
        lo <= quo_neg ? neg32(dvd) : dvd;
        hi <= rem_neg ? neg32(rem[31:0]) : rem[31:0];
      end

      if (wr_hi) hi <= a;
      if (wr_lo) lo <= a;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with a behavioural stand-in for the
// external multiplier and a queue of expected HI/LO results.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [31:0] mul_a, mul_b, mul_hi, mul_lo;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clock = ~clock;

  logic signed [63:0] prod;
  assign prod = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
  assign mul_hi = prod[63:32];
  assign mul_lo = prod[31:0];

  hilo_muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_hi      (mul_hi),
    .mul_lo      (mul_lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input logic dbz, input int lat);
    exp_t e;
    e.hi  = h;
    e.lo  = l;
    e.dbz = dbz;
    e.lat = lat;
    sb.push_back(e);
    m_hi = h;
    m_lo = l;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    op    = o;
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Waits for done after a start edge; optionally pulses an intruding start at poke_at.
  task automatic wait_done(input string tag, input int poke_at, input logic exp_busy);
    exp_t e;
    int   lat;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (k == 1) check32({tag, "_busy_first"}, 32'(busy), 32'(exp_busy));
      if (k == poke_at) begin
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'hDEADBEEF;
      end else if (k == poke_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    check32({tag, "_done_seen"}, 32'(lat != 0), 32'd1);
    if (lat != 0) begin
      check32({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check32({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check32({tag, "_hi"}, hi, e.hi);
        check32({tag, "_lo"}, lo, e.lo);
        check32({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
        check32({tag, "_busy_done"}, 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    longint      sa, sbv, q, r, p;
    logic [63:0] qv, rv, pv;
    logic [31:0] da, db;

    clear_n = 1'b0;
    start   = 1'b0;
    op      = OP_MUL;
    a       = '0;
    b       = '0;
    #12;
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    check32("rst_mul_a", mul_a, 32'd0);
    check32("rst_mul_b", mul_b, 32'd0);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_done", 32'(done), 32'd0);
    check32("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);

    push(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 3);
    issue(OP_MUL, 32'd7, 32'hFFFFFFFD);
    wait_done("mul_7x-3", 0, 1'b1);
    check32("mul_a_held", mul_a, 32'd7);
    check32("mul_b_held", mul_b, 32'hFFFFFFFD);
    @(negedge clock);

    push(32'h40000000, 32'h00000000, 1'b0, 3);
    issue(OP_MUL, 32'h80000000, 32'h80000000);
    wait_done("mul_min_sq", 0, 1'b1);
    @(negedge clock);

    push(32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 34);
    issue(OP_DIV, 32'hFFFFFFEF, 32'd5);
    wait_done("div_-17_5", 0, 1'b1);
    @(negedge clock);

    push(m_hi, m_lo, 1'b1, 1);
    issue(OP_DIV, 32'd100, 32'd0);
    wait_done("div_by_0", 0, 1'b0);
    @(negedge clock);

    push(32'h12345678, m_lo, 1'b0, 1);
    issue(OP_MTHI, 32'h12345678, 32'd0);
    wait_done("mthi", 0, 1'b0);
    push(m_hi, 32'h9ABCDEF0, 1'b0, 1);
    issue(OP_MTLO, 32'h9ABCDEF0, 32'd0);
    wait_done("mtlo_b2b", 0, 1'b0);
    @(negedge clock);

    push(32'd1, 32'hFFFFFFFD, 1'b0, 34);
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_done("div_poked", 5, 1'b1);
    @(negedge clock);

    push(32'd0, 32'h80000000, 1'b0, 34);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 0, 1'b1);
    @(negedge clock);

    push(32'd3, 32'd0, 1'b0, 34);
    issue(OP_DIV, 32'd3, 32'hFFFFFFF6);
    wait_done("div_small", 0, 1'b1);
    @(negedge clock);

    for (int i = 0; i < 4; i++) begin
      da = $urandom;
      db = $urandom >> $urandom_range(0, 28);
      if (db == 32'd0) db = 32'd3;
      if (i[0]) db = ~db + 32'd1;
      if (da == 32'h80000000 && db == 32'hFFFFFFFF) db = 32'd2;
      sa  = longint'($signed(da));
      sbv = longint'($signed(db));
      q   = sa / sbv;
      r   = sa % sbv;
      qv  = q;
      rv  = r;
      push(rv[31:0], qv[31:0], 1'b0, 34);
      issue(OP_DIV, da, db);
      wait_done("div_rand", 0, 1'b1);
      @(negedge clock);
    end

    for (int i = 0; i < 3; i++) begin
      da = $urandom;
      db = $urandom;
      p  = longint'($signed(da)) * longint'($signed(db));
      pv = p;
      push(pv[63:32], pv[31:0], 1'b0, 3);
      issue(OP_MUL, da, db);
      wait_done("mul_rand", 0, 1'b1);
      @(negedge clock);
    end

    issue(OP_DIV, 32'd1000, 32'd7);
    repeat (9) @(negedge clock);
    clear_n = 1'b0;
    #1;
    check32("abort_busy", 32'(busy), 32'd0);
    check32("abort_done", 32'(done), 32'd0);
    check32("abort_hi", hi, 32'd0);
    check32("abort_lo", lo, 32'd0);
    check32("abort_mul_a", mul_a, 32'd0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);

    push(32'd0, 32'd6, 1'b0, 3);
    issue(OP_MUL, 32'd2, 32'd3);
    wait_done("mul_after_rst", 0, 1'b1);
    @(negedge clock);

    check32("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
